// File: rtl/bus_arb_pkg.sv
// Shared constants and state encoding for the bus_arb8 round-robin arbiter.
package bus_arb_pkg;

    localparam int unsigned ARB_NREQ      = 8;
    localparam int unsigned ARB_MAX_BURST = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker: first set request at or after ptr, modulo 8.
module rr_pick8
    import bus_arb_pkg::*;
(
    input  logic [ARB_NREQ-1:0] req,
    input  logic [2:0]          ptr,
    output logic [2:0]          winner,
    output logic                any_req
);

    logic [2:0] idx;

    // Scan from the farthest offset down so the nearest request to ptr is assigned last.
    always_comb begin
        winner  = ptr;
        any_req = 1'b0;
        idx     = ptr;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arb8.sv
// 8:1 round-robin arbiter with registered word output and valid/ready handoff.
// Optional burst lock enabled by defining ARB_LOCK_EN.
module bus_arb8
    import bus_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_i,
`ifdef ARB_LOCK_EN
    input  logic [NREQ-1:0]       lock,
`endif
    output logic [2:0]            sel,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    arb_state_e        state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        sel_q, sel_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q;

    logic [NREQ-1:0]   eff_req;
    logic [2:0]        rr_win;
    logic              rr_any;
    logic [2:0]        pick_sel;
    logic              pick_any;
    logic [WIDTH-1:0]  word;

`ifdef ARB_LOCK_EN
    logic              hold_q, hold_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              lock_win;
`endif

    // The requester acked this cycle is masked so it cannot win twice on one request.
    assign eff_req = req & ~ack_q;

    rr_pick8 u_pick (
        .req     (eff_req),
        .ptr     (ptr_q),
        .winner  (rr_win),
        .any_req (rr_any)
    );

    always_comb begin
        pick_sel = rr_win;
        pick_any = rr_any;
`ifdef ARB_LOCK_EN
        lock_win = hold_q && req[sel_q];
        if (lock_win) begin
            pick_sel = sel_q;
            pick_any = 1'b1;
        end
`endif
    end

    always_comb begin
        word = '0;
        case (pick_sel)
            3'd0: word = data_i[0*WIDTH +: WIDTH];
            3'd1: word = data_i[1*WIDTH +: WIDTH];
            3'd2: word = data_i[2*WIDTH +: WIDTH];
            3'd3: word = data_i[3*WIDTH +: WIDTH];
            3'd4: word = data_i[4*WIDTH +: WIDTH];
            3'd5: word = data_i[5*WIDTH +: WIDTH];
            3'd6: word = data_i[6*WIDTH +: WIDTH];
            3'd7: word = data_i[7*WIDTH +: WIDTH];
            default: word = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        ack_d   = '0;
        data_d  = data_q;
        valid_d = valid_q;
`ifdef ARB_LOCK_EN
        hold_d  = hold_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE, ST_ACK: begin
`ifdef ARB_LOCK_EN
                hold_d = 1'b0;
                if (!lock_win) begin
                    cnt_d = '0;
                end
`endif
                if (pick_any) begin
                    sel_d   = pick_sel;
                    data_d  = word;
                    valid_d = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    valid_d       = 1'b0;
                    ack_d[sel_q]  = 1'b1;
                    state_d       = ST_ACK;
`ifdef ARB_LOCK_EN
                    // cnt counts words already taken in this burst; ptr freezes while held.
                    if (lock[sel_q] && ((cnt_q + 5'd1) < 5'(ARB_MAX_BURST))) begin
                        hold_d = 1'b1;
                        cnt_d  = cnt_q + 5'd1;
                    end else begin
                        hold_d = 1'b0;
                        cnt_d  = '0;
                        ptr_d  = sel_q + 3'd1;
                    end
`else
                    ptr_d = sel_q + 3'd1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            ack_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef ARB_LOCK_EN
            hold_q  <= 1'b0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= (state_d != ST_IDLE);
`ifdef ARB_LOCK_EN
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign sel       = sel_q;
    assign ack       = ack_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bus_arb8.sv
// Directed self-checking bench for bus_arb8; the lock scenario runs when ARB_LOCK_EN is defined.
module tb_bus_arb8;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [7:0]     req = 8'h00;
    logic [8*W-1:0] data_i = '0;
    logic           out_ready = 1'b0;
`ifdef ARB_LOCK_EN
    logic [7:0]     lock = 8'h00;
`endif
    logic [2:0]     sel;
    logic [7:0]     ack;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           busy;

    int total = 0;
    int bad   = 0;

    bus_arb8 #(.WIDTH(W), .NREQ(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_i    (data_i),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .sel       (sel),
        .ack       (ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 8'h00;
        out_ready = 1'b0;
        data_i    = '0;
`ifdef ARB_LOCK_EN
        lock      = 8'h00;
`endif
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({sel, ack, out_data, out_valid, busy} !== 45'h0) begin
            bad++;
            $display("FAIL reset_vals got=%h want=0", {sel, ack, out_data, out_valid, busy});
        end
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if ({out_valid, busy, ack, sel} !== 13'h0) begin
                bad++;
                $display("FAIL idle_quiet[%0d] got=%h want=0", i, {out_valid, busy, ack, sel});
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        data_i[3*W +: W] = 32'hDEADBEEF;
        data_i[4*W +: W] = 32'h44444444;
        data_i[0*W +: W] = 32'h000000A0;
        req       = 8'h08;
        out_ready = 1'b1;
        step();
        total++;
        if ({out_valid, busy, sel, out_data, ack} !== {1'b1, 1'b1, 3'd3, 32'hDEADBEEF, 8'h00}) begin
            bad++;
            $display("FAIL single_send got v=%b b=%b sel=%0d d=%h ack=%h want 1 1 3 deadbeef 00",
                     out_valid, busy, sel, out_data, ack);
        end
        step();
        total++;
        if ({out_valid, busy, ack} !== {1'b0, 1'b1, 8'h08}) begin
            bad++;
            $display("FAIL single_ack got v=%b b=%b ack=%h want 0 1 08", out_valid, busy, ack);
        end
        req = 8'h00;
        step();
        total++;
        if ({out_valid, busy, ack, sel} !== {1'b0, 1'b0, 8'h00, 3'd3}) begin
            bad++;
            $display("FAIL single_idle got v=%b b=%b ack=%h sel=%0d want 0 0 00 3",
                     out_valid, busy, ack, sel);
        end
        // ptr must now be 4: requester 4 beats requester 0.
        req = 8'h11;
        step();
        total++;
        if ({sel, out_data} !== {3'd4, 32'h44444444}) begin
            bad++;
            $display("FAIL ptr_after_3 got sel=%0d d=%h want 4 44444444", sel, out_data);
        end
        step();
        req = req & ~ack;
        step();
        total++;
        if ({sel, out_data, out_valid} !== {3'd0, 32'h000000A0, 1'b1}) begin
            bad++;
            $display("FAIL wrap_to_0 got sel=%0d d=%h v=%b want 0 000000a0 1", sel, out_data, out_valid);
        end
        step();
        req = req & ~ack;
        step();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ks;
        logic [31:0] kd;
        logic [7:0]  ka;
        do_reset();
        for (int k = 0; k < 8; k++) data_i[k*W +: W] = 32'hA0000000 + 32'(k);
        req       = 8'hFF;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ks = 3'(k);
            kd = 32'hA0000000 + 32'(k);
            ka = 8'h01 << k;
            step();
            total++;
            if ({out_valid, sel, out_data, ack} !== {1'b1, ks, kd, 8'h00}) begin
                bad++;
                $display("FAIL rr_send[%0d] got v=%b sel=%0d d=%h ack=%h want 1 %0d %h 00",
                         k, out_valid, sel, out_data, ack, ks, kd);
            end
            step();
            total++;
            if ({out_valid, ack, busy} !== {1'b0, ka, 1'b1}) begin
                bad++;
                $display("FAIL rr_ack[%0d] got v=%b ack=%h b=%b want 0 %h 1", k, out_valid, ack, busy, ka);
            end
            req = req & ~ack;
        end
        step();
        total++;
        if ({out_valid, busy, ack} !== 10'h0) begin
            bad++;
            $display("FAIL rr_drain got v=%b b=%b ack=%h want 0 0 00", out_valid, busy, ack);
        end
        // After granting 7, ptr wraps to 0, so 0 beats 7.
        req = 8'h81;
        step();
        total++;
        if (sel !== 3'd0) begin
            bad++;
            $display("FAIL rr_wrap got sel=%0d want 0", sel);
        end
        step();
        req = req & ~ack;
        step();
        total++;
        if (sel !== 3'd7) begin
            bad++;
            $display("FAIL rr_after_wrap got sel=%0d want 7", sel);
        end
        step();
        req = req & ~ack;
        step();
    endtask

    task automatic test_stall();
        do_reset();
        data_i[2*W +: W] = 32'h11111111;
        req       = 8'h04;
        out_ready = 1'b0;
        step();
        total++;
        if ({out_valid, sel, out_data} !== {1'b1, 3'd2, 32'h11111111}) begin
            bad++;
            $display("FAIL stall_send got v=%b sel=%0d d=%h want 1 2 11111111", out_valid, sel, out_data);
        end
        for (int i = 0; i < 5; i++) begin
            data_i[2*W +: W] = 32'hBAD00000 + 32'(i);
            step();
            total++;
            if ({out_valid, busy, sel, out_data, ack} !== {1'b1, 1'b1, 3'd2, 32'h11111111, 8'h00}) begin
                bad++;
                $display("FAIL stall_hold[%0d] got v=%b b=%b sel=%0d d=%h ack=%h want 1 1 2 11111111 00",
                         i, out_valid, busy, sel, out_data, ack);
            end
        end
        out_ready = 1'b1;
        step();
        total++;
        if ({out_valid, ack} !== {1'b0, 8'h04}) begin
            bad++;
            $display("FAIL stall_release got v=%b ack=%h want 0 04", out_valid, ack);
        end
        req = 8'h00;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        data_i[3*W +: W] = 32'h33333333;
        data_i[5*W +: W] = 32'h55555555;
        data_i[0*W +: W] = 32'h0000000A;
        req       = 8'h08;
        out_ready = 1'b1;
        step();
        step();
        req = 8'h00;
        step();
        // ptr is 4 here; requester 5 enters SEND and stalls.
        out_ready = 1'b0;
        req       = 8'h20;
        step();
        total++;
        if ({out_valid, sel, out_data} !== {1'b1, 3'd5, 32'h55555555}) begin
            bad++;
            $display("FAIL mid_send got v=%b sel=%0d d=%h want 1 5 55555555", out_valid, sel, out_data);
        end
        step();
        rst_n = 1'b0;
        #1;
        total++;
        if ({sel, ack, out_data, out_valid, busy} !== 45'h0) begin
            bad++;
            $display("FAIL mid_async_clear got=%h want=0", {sel, ack, out_data, out_valid, busy});
        end
        out_ready = 1'b1;
        step();
        total++;
        if (ack !== 8'h00) begin
            bad++;
            $display("FAIL mid_no_ack got ack=%h want 00", ack);
        end
        rst_n = 1'b1;
        req   = 8'h21;
        step();
        total++;
        if ({sel, out_data, ack} !== {3'd0, 32'h0000000A, 8'h00}) begin
            bad++;
            $display("FAIL mid_ptr_reset got sel=%0d d=%h ack=%h want 0 0000000a 00", sel, out_data, ack);
        end
        step();
        req = req & ~ack;
        step();
        total++;
        if ({sel, out_data, out_valid} !== {3'd5, 32'h55555555, 1'b1}) begin
            bad++;
            $display("FAIL mid_regrant got sel=%0d d=%h v=%b want 5 55555555 1", sel, out_data, out_valid);
        end
        step();
        total++;
        if (ack !== 8'h20) begin
            bad++;
            $display("FAIL mid_regrant_ack got ack=%h want 20", ack);
        end
        req = 8'h00;
        step();
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        int          n2;
        logic [2:0]  es;
        logic [31:0] ed;
        logic [7:0]  ea;
        do_reset();
        n2 = 0;
        data_i[2*W +: W] = 32'h20000000;
        data_i[6*W +: W] = 32'h66666666;
        req       = 8'h44;
        lock      = 8'h04;
        out_ready = 1'b1;
        for (int g = 0; g < 21; g++) begin
            es = (g == 16) ? 3'd6 : 3'd2;
            ed = (g == 16) ? 32'h66666666 : 32'h20000000 + 32'(n2);
            ea = (g == 16) ? 8'h40 : 8'h04;
            step();
            total++;
            if ({out_valid, sel, out_data} !== {1'b1, es, ed}) begin
                bad++;
                $display("FAIL lock_grant[%0d] got v=%b sel=%0d d=%h want 1 %0d %h",
                         g, out_valid, sel, out_data, es, ed);
            end
            step();
            total++;
            if (ack !== ea) begin
                bad++;
                $display("FAIL lock_ack[%0d] got ack=%h want %h", g, ack, ea);
            end
            if (g == 16) begin
                req[6] = 1'b0;
            end else begin
                n2++;
                data_i[2*W +: W] = 32'h20000000 + 32'(n2);
                if (n2 == 20) begin
                    req[2]  = 1'b0;
                    lock[2] = 1'b0;
                end
            end
        end
        step();
        total++;
        if ({out_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL lock_drain got v=%b b=%b want 0 0", out_valid, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
